// File: rtl/macro_decode_sched.sv
// Pass scheduler for the compute-macro array: fires every macro, waits for all done flags,
// then accumulates the decoded per-channel sums. Optional watchdog: define MACRO_WATCHDOG_EN.
module macro_decode_sched #(
  parameter int CHANNEL_NUM = 128,
  parameter int MACRO_NUM   = 4,
  parameter int ACC_WIDTH   = 10,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [3:0]                       cfg_pass_num,
  output logic [MACRO_NUM-1:0]             macro_en,
  input  logic [MACRO_NUM-1:0]             macro_done,
  input  logic [CHANNEL_NUM*MACRO_NUM*4-1:0] dec_data,
  output logic [CHANNEL_NUM*ACC_WIDTH-1:0] out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             busy,
  output logic                             err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRE,
    S_WAIT,
    S_ACC,
    S_OUT
  } state_t;

  state_t state, state_nxt;

  logic [3:0]                  pass_num;
  logic [3:0]                  pass_cnt;
  logic [MACRO_NUM-1:0]        done_mask;
  logic                        all_done;
  logic                        timeout;
  logic signed [ACC_WIDTH-1:0] acc      [CHANNEL_NUM];
  logic signed [ACC_WIDTH-1:0] pass_sum [CHANNEL_NUM];

  // This cycle's done pulses count too, so a pass can leave WAIT on the same cycle the last one lands
  assign all_done = &(done_mask | macro_done);

`ifdef MACRO_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state == S_FIRE) begin
      wd_cnt <= '0;
    end else if (state == S_WAIT) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign timeout = (state == S_WAIT) && !all_done && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (timeout) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_FIRE;
        end
      end
      S_FIRE: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (all_done) begin
          state_nxt = S_ACC;
        end else if (timeout) begin
          state_nxt = S_IDLE;
        end
      end
      S_ACC: begin
        if (pass_cnt + 4'd1 == pass_num) begin
          state_nxt = S_OUT;
        end else begin
          state_nxt = S_FIRE;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    macro_en  = '0;
    out_valid = 1'b0;
    busy      = (state != S_IDLE);
    if (state == S_FIRE) begin
      macro_en = '1;
    end
    if (state == S_OUT) begin
      out_valid = 1'b1;
    end
  end

  // Sign-extend each 4-bit decoded field and sum the macros of a channel; wraps at ACC_WIDTH
  always_comb begin
    logic [3:0] fld;
    fld = '0;
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      pass_sum[c] = '0;
      for (int m = 0; m < MACRO_NUM; m++) begin
        fld = dec_data[(c*MACRO_NUM+m)*4 +: 4];
        pass_sum[c] = pass_sum[c] + {{(ACC_WIDTH-4){fld[3]}}, fld};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_num  <= '0;
      pass_cnt  <= '0;
      done_mask <= '0;
      for (int c = 0; c < CHANNEL_NUM; c++) begin
        acc[c] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pass_num <= (cfg_pass_num == 4'd0) ? 4'd1 : cfg_pass_num;
            pass_cnt <= '0;
            for (int c = 0; c < CHANNEL_NUM; c++) begin
              acc[c] <= '0;
            end
          end
        end
        S_FIRE: begin
          done_mask <= '0;
        end
        S_WAIT: begin
          done_mask <= done_mask | macro_done;
          if (timeout) begin
            for (int c = 0; c < CHANNEL_NUM; c++) begin
              acc[c] <= '0;
            end
          end
        end
        S_ACC: begin
          pass_cnt <= pass_cnt + 4'd1;
          for (int c = 0; c < CHANNEL_NUM; c++) begin
            acc[c] <= acc[c] + pass_sum[c];
          end
        end
        default: begin
        end
      endcase
    end
  end

  for (genvar gc = 0; gc < CHANNEL_NUM; gc++) begin : g_out
    assign out_data[gc*ACC_WIDTH +: ACC_WIDTH] = acc[gc];
  end

endmodule

// File: tb/tb_macro_decode_sched.sv
// Scoreboard bench for macro_decode_sched: a small macro responder drives done pulses and
// decoded data per pass; expected channel sums are queued per job and checked at the handshake.
module tb_macro_decode_sched;

  localparam int CH = 128;
  localparam int MN = 4;
  localparam int AW = 10;
  localparam int OW = CH * AW;
  localparam int DW = CH * MN * 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [3:0]    cfg_pass_num;
  logic [MN-1:0] macro_en;
  logic [MN-1:0] macro_done;
  logic [DW-1:0] dec_data;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          err;

  int            total = 0;
  int            bad = 0;
  logic [OW-1:0] sb_q[$];
  int            exp_acc[CH];
  int            dly[MN];

  macro_decode_sched #(
    .CHANNEL_NUM(CH),
    .MACRO_NUM(MN),
    .ACC_WIDTH(AW),
    .TIMEOUT_CYC(255)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .cfg_pass_num(cfg_pass_num),
    .macro_en(macro_en),
    .macro_done(macro_done),
    .dec_data(dec_data),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // sel 0: all +7, 1: all -8, 2: channel c gets c%8-4 on every macro, else random
  function automatic logic [DW-1:0] makePattern(input int sel);
    logic [DW-1:0] pat;
    int v;
    pat = '0;
    for (int c = 0; c < CH; c++) begin
      for (int m = 0; m < MN; m++) begin
        case (sel)
          0:       v = 7;
          1:       v = -8;
          2:       v = (c % 8) - 4;
          default: v = int'($urandom_range(0, 15)) - 8;
        endcase
        pat[(c*MN+m)*4 +: 4] = 4'(v);
      end
    end
    return pat;
  endfunction

  function automatic void addPattern(input logic [DW-1:0] pat);
    int f;
    for (int c = 0; c < CH; c++) begin
      for (int m = 0; m < MN; m++) begin
        f = int'(pat[(c*MN+m)*4 +: 4]);
        exp_acc[c] += (f >= 8) ? f - 16 : f;
      end
    end
  endfunction

  function automatic logic [OW-1:0] packExpected();
    logic [OW-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      r[c*AW +: AW] = AW'(exp_acc[c]);
    end
    return r;
  endfunction

  task automatic setDelays(input int d0, input int d1, input int d2, input int d3);
    dly[0] = d0;
    dly[1] = d1;
    dly[2] = d2;
    dly[3] = d3;
  endtask

  task automatic waitFire(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (macro_en == '1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("fire_seen", ok, 1);
  endtask

  // One job; abort_pass>0 asserts rst in the first WAIT cycle of that pass
  task automatic applyStimulus(input int cfg, input int sel, input int hold, input bit pulse_start,
                               input int abort_pass);
    int np;
    int maxd;
    bit ok;
    logic [DW-1:0] pat;
    np = (cfg == 0) ? 1 : cfg;
    maxd = 0;
    for (int m = 0; m < MN; m++) begin
      if (dly[m] > maxd) maxd = dly[m];
    end
    for (int c = 0; c < CH; c++) exp_acc[c] = 0;
    @(negedge clk);
    cfg_pass_num = 4'(cfg);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_pass_num = 4'($urandom);
    for (int p = 0; p < np; p++) begin
      waitFire(ok);
      if (!ok) return;
      dec_data = makePattern(3);
      pat = makePattern(sel);
      for (int k = 1; k <= maxd; k++) begin
        @(negedge clk);
        if (abort_pass == p + 1) begin
          rst = 1'b1;
          macro_done = '0;
          @(negedge clk);
          checkOutput("rst_outputs", {out_data, busy, out_valid, macro_en, err}, 0);
          rst = 1'b0;
          for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst_quiet", {busy, out_valid}, 0);
          end
          return;
        end
        checkOutput("early_acc", {macro_en, out_valid}, 0);
        for (int m = 0; m < MN; m++) macro_done[m] = (dly[m] == k);
        if (k == maxd) dec_data = pat;
      end
      @(negedge clk);
      macro_done = '0;
      checkOutput("acc_no_valid", out_valid, 0);
      addPattern(pat);
      if (p == np - 1) sb_q.push_back(packExpected());
      @(negedge clk);
      dec_data = makePattern(3);
    end
    checkOutput("valid_up", out_valid, 1);
    checkOutput("sb_pending", sb_q.size(), 1);
    if (sb_q.size() == 0) return;
    for (int h = 0; h < hold; h++) begin
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_data", out_data, sb_q[0]);
      checkOutput("hold_no_fire", macro_en, 0);
      start = pulse_start && (h == 2);
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b1;
    checkOutput("hs_valid", out_valid, 1);
    checkOutput("out_data", out_data, sb_q.pop_front());
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("idle_after", {busy, out_valid, macro_en}, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("single_valid", {busy, out_valid}, 0);
    end
  endtask

`ifdef MACRO_WATCHDOG_EN
  task automatic watchdogTest();
    bit ok;
    setDelays(1, 1, 0, 1);
    @(negedge clk);
    cfg_pass_num = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitFire(ok);
    if (!ok) return;
    for (int k = 1; k <= 255; k++) begin
      @(negedge clk);
      for (int m = 0; m < MN; m++) macro_done[m] = (dly[m] == k);
      if (k == 255) checkOutput("wd_pending", {busy, err}, 2'b10);
    end
    @(negedge clk);
    macro_done = '0;
    checkOutput("wd_fired", {busy, out_valid, err}, 3'b001);
    checkOutput("wd_acc_clear", out_data, 0);
    setDelays(1, 1, 1, 1);
    applyStimulus(2, 3, 0, 1'b0, 0);
    checkOutput("err_sticky", err, 1);
  endtask
`endif

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cfg_pass_num = '0;
    macro_done = '0;
    dec_data = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_state", {out_data, busy, out_valid, macro_en, err}, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("ready_no_effect", {busy, out_valid}, 0);
    out_ready = 1'b0;

    setDelays(1, 1, 1, 1);
    applyStimulus(1, 0, 0, 1'b0, 0);
    applyStimulus(9, 1, 2, 1'b0, 0);
    setDelays(1, 2, 3, 5);
    applyStimulus(2, 2, 1, 1'b0, 0);
    setDelays(1, 1, 1, 1);
    applyStimulus(3, 3, 10, 1'b1, 0);
    applyStimulus(0, 3, 0, 1'b0, 0);
    applyStimulus(5, 3, 0, 1'b0, 3);
    setDelays(2, 1, 4, 3);
    applyStimulus(15, 3, 1, 1'b0, 0);
    checkOutput("err_idle", err, 0);
`ifdef MACRO_WATCHDOG_EN
    watchdogTest();
`endif
    checkOutput("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
